// File: rtl/uart_boot_loader.sv
// UART 8N1 program loader: deserializes bytes, packs them little-endian into
// 32-bit words and writes each word to consecutive addresses over pipelined Wishbone.
module uart_boot_loader #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
  parameter int unsigned WORD_COUNT   = 32
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_rx,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_data_o,
  input  logic        wb_ack,
  input  logic        wb_stall,
  output logic        boot_done,
  output logic        frame_err,
  output logic        overrun
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(WORD_COUNT + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_COUNT - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_ACK, W_DONE} wb_state_t;

  rx_state_t rx_state, rx_next;
  wb_state_t wb_state, wb_next;

  logic          rx_meta, rx_s;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_vld;
  logic          timer_clr, bit_shift, byte_ok, frame_hit;

  logic [1:0]    idx;
  logic [23:0]   word;
  logic [CW-1:0] cnt;
  logic          word_done;

  // ---------------- RX path ----------------
  always_comb begin
    rx_next   = rx_state;
    timer_clr = 1'b0;
    bit_shift = 1'b0;
    byte_ok   = 1'b0;
    frame_hit = 1'b0;
    case (rx_state)
      R_IDLE: if (!rx_s) begin
        rx_next   = R_START;
        timer_clr = 1'b1;
      end
      R_START: if (timer == HALF_M1) begin
        timer_clr = 1'b1;
        rx_next   = rx_s ? R_IDLE : R_DATA;
      end
      R_DATA: if (timer == FULL_M1) begin
        timer_clr = 1'b1;
        bit_shift = 1'b1;
        if (bit_idx == 3'd7) rx_next = R_STOP;
      end
      R_STOP: if (timer == FULL_M1) begin
        timer_clr = 1'b1;
        if (rx_s) begin
          byte_ok = 1'b1;
          rx_next = R_IDLE;
        end else begin
          frame_hit = 1'b1;
          rx_next   = R_BREAK;
        end
      end
      // Line held low past the stop bit: wait for it to return idle.
      R_BREAK: if (rx_s) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_state  <= R_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= uart_rx;
      rx_s      <= rx_meta;
      rx_state  <= rx_next;
      timer     <= timer_clr ? '0 : timer + 1'b1;
      if (rx_state == R_START) bit_idx <= '0;
      else if (bit_shift)      bit_idx <= bit_idx + 3'd1;
      if (bit_shift) shreg <= {rx_s, shreg[7:1]};
      byte_vld  <= byte_ok;
      frame_err <= frame_err | frame_hit;
    end
  end

  // ---------------- Word assembly and Wishbone master ----------------
  // shreg stays stable during the byte_vld cycle, so it serves as the received byte.
  assign word_done = byte_vld && (idx == 2'd3) && (wb_state != W_DONE);

  always_comb begin
    wb_next = wb_state;
    case (wb_state)
      W_IDLE:  if (word_done) wb_next = W_REQ;
      W_REQ:   if (!wb_stall) wb_next = W_ACK;
      W_ACK:   if (wb_ack) wb_next = (cnt == CNT_LAST) ? W_DONE : W_IDLE;
      W_DONE:  wb_next = W_DONE;
      default: wb_next = W_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wb_state  <= W_IDLE;
      idx       <= '0;
      word      <= '0;
      wb_data_o <= '0;
      wb_addr   <= ADDR_BASE;
      cnt       <= '0;
      overrun   <= 1'b0;
    end else begin
      wb_state <= wb_next;
      if (byte_vld && wb_state != W_DONE) begin
        idx <= idx + 2'd1;
        case (idx)
          2'd0:    word[7:0]   <= shreg;
          2'd1:    word[15:8]  <= shreg;
          2'd2:    word[23:16] <= shreg;
          default: ;
        endcase
      end
      // A word finishing while a write is in flight is dropped, not queued.
      if (word_done && wb_state == W_IDLE) wb_data_o <= {shreg, word};
      if (word_done && wb_state != W_IDLE) overrun   <= 1'b1;
      if (wb_state == W_ACK && wb_ack) begin
        wb_addr <= wb_addr + 32'd4;
        cnt     <= cnt + CW'(1);
      end
    end
  end

  assign wb_cyc    = (wb_state == W_REQ) || (wb_state == W_ACK);
  assign wb_stb    = (wb_state == W_REQ);
  assign wb_we     = wb_cyc;
  assign wb_sel    = wb_cyc ? 4'hF : 4'h0;
  assign boot_done = (wb_state == W_DONE);

endmodule
